calc_input_conditioner: RTL and testbench
=========================================

// Module: calc_input_conditioner
// PURPOSE
//  Front-end stage feeding the calculator core. Turns a raw, bouncing Enter push-button and
//  raw slide switches (operand, opcode) into one clean single-cycle Enter pulse per press.
//  NumIn/OpIn are registered and change only on a pulse, so the core samples stable data.
// PARAMETERS
//  SYNC_STAGES      2     synchronizer flops on BtnRaw, SwNum and SwOp (>=2)
//  DEBOUNCE_CYCLES  1000  consecutive stable cycles needed to accept a press or release (>=1)
//  REPEAT_DELAY     50000 cycles held before the first auto-repeat pulse (macro only)
//  REPEAT_PERIOD    10000 cycles between subsequent auto-repeat pulses (>=2, macro only)
// PORTS
//  clock   in   1  system clock, all logic on posedge
//  Reset   in   1  asynchronous, active-high reset
//  BtnRaw  in   1  raw Enter button, asynchronous, may bounce
//  SwNum   in   8  raw operand switches, asynchronous
//  SwOp    in   2  raw opcode switches, asynchronous
//  Enter   out  1  one-cycle accept pulse to the core
//  NumIn   out  8  registered operand, valid while Enter=1 and held until the next pulse
//  OpIn    out  2  registered opcode, same timing as NumIn
//  Held    out  1  1 while FSM in HELD or RELEASE_WAIT (debounced button down)
// BEHAVIOUR
//  Reset: all sync flops 0, FSM=IDLE, counters 0, Enter=0, NumIn=0, OpIn=0, Held=0.
//  Sync: BtnRaw/SwNum/SwOp pass through SYNC_STAGES flops; FSM sees only btn_s, sw_s.
//  FSM (cnt is a debounce counter, cleared on every state change):
//   IDLE:         btn_s=1 -> PRESS_WAIT.
//   PRESS_WAIT:   btn_s=0 -> IDLE (bounce rejected, no pulse); else cnt++;
//                 btn_s=1 with cnt==DEBOUNCE_CYCLES-1 -> HELD; same edge: Enter<=1,
//                 NumIn<=sw_s num, OpIn<=sw_s op.
//   HELD:         btn_s=0 -> RELEASE_WAIT.
//   RELEASE_WAIT: btn_s=1 -> HELD (release bounce, no new pulse); else cnt++;
//                 btn_s=0 with cnt==DEBOUNCE_CYCLES-1 -> IDLE.
//  Enter is registered and high exactly one cycle per accepted pulse. It is always followed
//   by >=1 low cycle, so the core's press-edge detection sees every pulse.
//  Latency (SYNC_STAGES=2): BtnRaw stable 1 from edge 1 -> Enter high after edge
//   DEBOUNCE_CYCLES+3 and low after edge DEBOUNCE_CYCLES+4.
//  Switch changes with no pulse never alter NumIn/OpIn. Switch bounce around a press is
//   tolerated: the value latched is sw_s at the accept edge.
//  Button released during PRESS_WAIT at any count: no pulse, state returns to IDLE.
//  Reset mid-press: immediate return to IDLE with outputs 0. A button still held after
//   Reset deasserts counts as a new press and gets a full debounce before pulsing.
//  Counters are sized by $clog2 of the largest count; no wrap occurs in any legal state.
// CONFIGURATION
//  CALC_INPUT_REPEAT_EN defined: in HELD a repeat counter runs. Enter pulses (with switch
//   relatch) after REPEAT_DELAY cycles in HELD, then every REPEAT_PERIOD cycles while HELD.
//   The repeat counter clears on leaving HELD. A bounce back to HELD from RELEASE_WAIT
//   restarts REPEAT_DELAY.
//  Not defined: exactly one pulse per press. REPEAT_* are unused and no repeat logic is built.
// TESTING (bench uses SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  Clean press, SwNum=8'h2A SwOp=2'd1, hold 20 cycles -> one Enter pulse after edge 7,
//   NumIn=8'h2A OpIn=1 from then on, Held=1.
//  Press bouncing 1,0,1,1,0 then stable 1 -> exactly one pulse, 4 stable cycles after the
//   last 0 reaches the FSM. Press of 3 cycles -> no pulse, Held stays 0.
//  Release with 2-cycle bounce after HELD -> no second pulse. Held drops 4 stable-low cycles
//   later. Next press yields a new pulse.
//  SwNum changed 8'h2A->8'h55 while idle, no press -> NumIn stays 8'h2A. Next press ->
//   NumIn=8'h55.
//  Reset asserted in PRESS_WAIT and in HELD with the button held -> outputs 0 at once.
//   After release of Reset, one pulse after a full debounce.
//  CALC_INPUT_REPEAT_EN: hold 25 cycles past accept -> pulses at accept, +10, +13, +16, ...
//   Without the macro, the same stimulus gives the single accept pulse only.

Source files
------------

// File: rtl/calc_input_conditioner.sv
// -----------------------------------------------------------------------------
// calc_input_conditioner
//
// Front end of the calculator core. Synchronizes a raw, bouncing Enter button
// and raw operand/opcode slide switches, debounces the button with a four-state
// FSM, and emits one clean single-cycle Enter pulse per accepted press. The
// switch values are latched into NumIn/OpIn only on that pulse, so the core
// always samples stable data.
//
// Build option:
//   CALC_INPUT_REPEAT_EN  when defined, a button held in HELD auto-repeats:
//                         a pulse after REPEAT_DELAY cycles, then one every
//                         REPEAT_PERIOD cycles. When undefined no repeat logic
//                         exists and there is exactly one pulse per press.
//
// Parameters:
//   SYNC_STAGES      synchronizer depth on BtnRaw/SwNum/SwOp (>= 2)
//   DEBOUNCE_CYCLES  stable cycles needed to accept a press or release (>= 1)
//   REPEAT_DELAY     cycles in HELD before the first auto-repeat pulse
//   REPEAT_PERIOD    cycles between later auto-repeat pulses (>= 2)
//
// Ports:
//   clock   in   1  system clock, all logic on posedge
//   Reset   in   1  asynchronous, active-high reset
//   BtnRaw  in   1  raw Enter button (asynchronous, may bounce)
//   SwNum   in   8  raw operand switches (asynchronous)
//   SwOp    in   2  raw opcode switches (asynchronous)
//   Enter   out  1  one-cycle accept pulse to the core
//   NumIn   out  8  operand latched on the pulse, held until the next pulse
//   OpIn    out  2  opcode latched on the pulse, same timing as NumIn
//   Held    out  1  debounced button down (FSM in HELD or RELEASE_WAIT)
//
// Handshake: Enter is a valid strobe with no ready/backpressure. NumIn/OpIn
// are valid in the cycle Enter=1 and stay unchanged until the next Enter.
// Every Enter=1 cycle is followed by at least one Enter=0 cycle, so an
// edge detector in the core sees every pulse.
//
// The FSM state is kept in the named enum register state_q for observation.
// -----------------------------------------------------------------------------
module calc_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 50000,
  parameter int REPEAT_PERIOD   = 10000
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       BtnRaw,
  input  logic [7:0] SwNum,
  input  logic [1:0] SwOp,
  output logic       Enter,
  output logic [7:0] NumIn,
  output logic [1:0] OpIn,
  output logic       Held
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter legality
  // ---------------------------------------------------------------------------
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_DELAY < 2) begin : g_bad_delay
    $error("REPEAT_DELAY must be at least 2");
  end
  if (REPEAT_PERIOD < 2) begin : g_bad_period
    $error("REPEAT_PERIOD must be at least 2");
  end

  // Debounce counter only ever reaches DEBOUNCE_CYCLES-1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizers: bit [0] is the first flop, bit [SYNC_STAGES-1] the output.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0]      btn_sync;
  logic [SYNC_STAGES-1:0][7:0] num_sync;
  logic [SYNC_STAGES-1:0][1:0] op_sync;

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      btn_sync <= '0;
      num_sync <= '0;
      op_sync  <= '0;
    end else begin
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], BtnRaw};
      num_sync <= {num_sync[SYNC_STAGES-2:0], SwNum};
      op_sync  <= {op_sync[SYNC_STAGES-2:0], SwOp};
    end
  end

  logic       btn_s;
  logic [7:0] num_s;
  logic [1:0] op_s;

  assign btn_s = btn_sync[SYNC_STAGES-1];
  assign num_s = num_sync[SYNC_STAGES-1];
  assign op_s  = op_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt is cleared on every state transition, so each wait state starts its
  // count at zero and the first sample that entered it is not counted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_s) begin
          // Bounce during press: drop it without a pulse.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!btn_s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (btn_s) begin
          // Bounce during release: back to HELD, no new pulse.
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign Held = (state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT);

  // ---------------------------------------------------------------------------
  // Pulse source: press accept, plus auto-repeat when built in.
  // ---------------------------------------------------------------------------
  logic pulse;

`ifdef CALC_INPUT_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] REP_FIRST_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_NEXT_LAST  = REP_W'(REPEAT_PERIOD - 1);

  // rep_periodic_q is 0 until the first repeat of a HELD stay has fired; it
  // selects between the initial delay and the steady repeat period.
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_periodic_q, rep_periodic_d;
  logic             rep_fire;
  logic [REP_W-1:0] rep_last;

  assign rep_last = rep_periodic_q ? REP_NEXT_LAST : REP_FIRST_LAST;

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      rep_cnt_q      <= '0;
      rep_periodic_q <= 1'b0;
    end else begin
      rep_cnt_q      <= rep_cnt_d;
      rep_periodic_q <= rep_periodic_d;
    end
  end

  // Counts only cycles spent in HELD with the button still down; any other
  // cycle (including the one leaving HELD) restarts the initial delay.
  always_comb begin
    rep_cnt_d      = rep_cnt_q;
    rep_periodic_d = rep_periodic_q;
    rep_fire       = 1'b0;
    if (state_q == ST_HELD && btn_s) begin
      if (rep_cnt_q == rep_last) begin
        rep_fire       = 1'b1;
        rep_cnt_d      = '0;
        rep_periodic_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end else begin
      rep_cnt_d      = '0;
      rep_periodic_d = 1'b0;
    end
  end

  assign pulse = accept | rep_fire;
`else
  assign pulse = accept;
`endif

  // ---------------------------------------------------------------------------
  // Registered outputs: switches are relatched only on a pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      Enter <= 1'b0;
      NumIn <= '0;
      OpIn  <= '0;
    end else begin
      Enter <= pulse;
      if (pulse) begin
        NumIn <= num_s;
        OpIn  <= op_s;
      end
    end
  end

endmodule

// File: tb/tb_calc_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_calc_input_conditioner
//
// Directed and randomized stimulus for calc_input_conditioner. A behavioural
// model tracks the debounced button level as "consecutive synchronized samples
// that disagree with the current level": DEBOUNCE_CYCLES+1 of them flip the
// level, a rising flip is an accepted press. Hold time in the debounced-down,
// non-bouncing condition drives the optional auto-repeat.
// -----------------------------------------------------------------------------
module tb_calc_input_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;

`ifdef CALC_INPUT_REPEAT_EN
  // Accept at edge 7, repeats at 17, 20, 23, 26, 29, 32, 35.
  localparam int CLEAN_PULSES = 8;
`else
  localparam int CLEAN_PULSES = 1;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clock = 1'b0;
  logic       Reset;
  logic       BtnRaw;
  logic [7:0] SwNum;
  logic [1:0] SwOp;
  logic       Enter;
  logic [7:0] NumIn;
  logic [1:0] OpIn;
  logic       Held;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  calc_input_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clock (clock),
    .Reset (Reset),
    .BtnRaw(BtnRaw),
    .SwNum (SwNum),
    .SwOp  (SwOp),
    .Enter (Enter),
    .NumIn (NumIn),
    .OpIn  (OpIn),
    .Held  (Held)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  logic [11:0] exp_q[$];   // {held, enter, op[1:0], num[7:0]}
  logic [11:0] exp_e;

  int   pulse_cnt   = 0;
  int   first_pulse = -1;
  logic held_seen   = 1'b0;
  int   t0          = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic       m_btn_p [SYNC];
  logic [7:0] m_num_p [SYNC];
  logic [1:0] m_op_p  [SYNC];
  logic       m_db;
  int         m_run;
  int         m_age;
  logic       m_enter;
  logic [7:0] m_num;
  logic [1:0] m_op;

  task automatic model_step();
    logic       bs;
    logic [7:0] ns;
    logic [1:0] os;
    logic       fire;
    if (Reset) begin
      for (int i = 0; i < SYNC; i++) begin
        m_btn_p[i] = 1'b0;
        m_num_p[i] = 8'h00;
        m_op_p[i]  = 2'd0;
      end
      m_db    = 1'b0;
      m_run   = 0;
      m_age   = 0;
      m_enter = 1'b0;
      m_num   = 8'h00;
      m_op    = 2'd0;
      exp_q.delete();
      exp_q.push_back(12'h000);
      return;
    end
    bs = m_btn_p[SYNC-1];
    ns = m_num_p[SYNC-1];
    os = m_op_p[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) begin
      m_btn_p[i] = m_btn_p[i-1];
      m_num_p[i] = m_num_p[i-1];
      m_op_p[i]  = m_op_p[i-1];
    end
    m_btn_p[0] = BtnRaw;
    m_num_p[0] = SwNum;
    m_op_p[0]  = SwOp;

    fire = 1'b0;
    if (bs != m_db) begin
      m_run++;
      m_age = 0;
      if (m_run == DEB + 1) begin
        m_db  = bs;
        m_run = 0;
        fire  = bs;
      end
    end else begin
      if (m_db && m_run == 0) begin
        m_age++;
`ifdef CALC_INPUT_REPEAT_EN
        if (m_age >= RD && ((m_age - RD) % RP) == 0) fire = 1'b1;
`endif
      end else begin
        m_age = 0;
      end
      m_run = 0;
    end
    m_enter = fire;
    if (fire) begin
      m_num = ns;
      m_op  = os;
    end
    exp_q.push_back({m_db, m_enter, m_op, m_num});
  endtask

  always @(posedge clock or posedge Reset) model_step();

  // ---------------------------------------------------------------------------
  // Continuous output checker on the falling edge
  // ---------------------------------------------------------------------------
  task automatic observe();
    if (exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      if (chk_en) begin
        check("enter", 8'(Enter), 8'(exp_e[10]));
        check("num_in", NumIn, exp_e[7:0]);
        check("op_in", 8'(OpIn), 8'(exp_e[9:8]));
        check("held", 8'(Held), 8'(exp_e[11]));
      end
    end
    if (chk_en) begin
      if (Enter) begin
        pulse_cnt++;
        if (first_pulse < 0) first_pulse = cyc;
      end
      if (Held) held_seen = 1'b1;
    end
  endtask

  always @(negedge clock) observe();

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  task automatic measure_start();
    pulse_cnt   = 0;
    first_pulse = -1;
    held_seen   = 1'b0;
    t0          = cyc;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_enter"}, 8'(Enter), 8'h00);
    check({tag, "_num"}, NumIn, 8'h00);
    check({tag, "_op"}, 8'(OpIn), 8'h00);
    check({tag, "_held"}, 8'(Held), 8'h00);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic bounce_seq [5];
  int   t_rel;
  int   t1;

  initial begin
    Reset  = 1'b1;
    BtnRaw = 1'b0;
    SwNum  = 8'h00;
    SwOp   = 2'd0;
    step(3);
    Reset  = 1'b0;
    chk_en = 1'b1;
    settle();
    check_reset_outputs("reset");

    // Clean press with switches 2A/1, held long enough to cover repeats.
    SwNum = 8'h2A;
    SwOp  = 2'd1;
    step(3);
    measure_start();
    BtnRaw = 1'b1;
    step(35);
    settle();
    check("clean_offset", 8'(first_pulse - t0), 8'd7);
    check("clean_pulses", 8'(pulse_cnt), 8'(CLEAN_PULSES));
    check("clean_num", NumIn, 8'h2A);
    check("clean_op", 8'(OpIn), 8'd1);
    check("clean_held", 8'(Held), 8'd1);

    // Release with a bounce back up for two cycles.
    measure_start();
    BtnRaw = 1'b0;
    step(1);
    BtnRaw = 1'b1;
    step(2);
    BtnRaw = 1'b0;
    t_rel  = cyc;
    step(6);
    check("release_held_still", 8'(Held), 8'd1);
    step(1);
    check("release_held_drop", 8'(Held), 8'd0);
    check("release_cyc", 8'(cyc - t_rel), 8'd7);
    step(5);
    check("release_no_pulse", 8'(pulse_cnt), 8'd0);

    // Next press yields a fresh pulse.
    measure_start();
    BtnRaw = 1'b1;
    step(12);
    check("repress_offset", 8'(first_pulse - t0), 8'd7);
    check("repress_pulses", 8'(pulse_cnt), 8'd1);
    BtnRaw = 1'b0;
    step(10);

    // Bouncing press 1,0,1,1,0 then stable high.
    bounce_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    measure_start();
    for (int i = 0; i < 5; i++) begin
      BtnRaw = bounce_seq[i];
      step(1);
    end
    t1     = cyc;
    BtnRaw = 1'b1;
    step(12);
    check("bounce_offset", 8'(first_pulse - t1), 8'd7);
    check("bounce_pulses", 8'(pulse_cnt), 8'd1);
    BtnRaw = 1'b0;
    step(10);

    // Press of only three cycles is rejected.
    measure_start();
    BtnRaw = 1'b1;
    step(3);
    BtnRaw = 1'b0;
    step(10);
    check("short_pulses", 8'(pulse_cnt), 8'd0);
    check("short_held", 8'(held_seen), 8'd0);

    // Switch change while idle must not reach NumIn/OpIn.
    SwNum = 8'h55;
    SwOp  = 2'd2;
    step(6);
    check("idle_num_kept", NumIn, 8'h2A);
    check("idle_op_kept", 8'(OpIn), 8'd1);
    measure_start();
    BtnRaw = 1'b1;
    step(12);
    check("relatch_num", NumIn, 8'h55);
    check("relatch_op", 8'(OpIn), 8'd2);
    check("relatch_pulses", 8'(pulse_cnt), 8'd1);
    BtnRaw = 1'b0;
    step(10);

    // Reset while in PRESS_WAIT, button kept down.
    BtnRaw = 1'b1;
    step(5);
    Reset = 1'b1;
    #1;
    check_reset_outputs("rst_press");
    step(2);
    Reset = 1'b0;
    measure_start();
    step(12);
    check("rst_press_offset", 8'(first_pulse - t0), 8'd7);
    check("rst_press_pulses", 8'(pulse_cnt), 8'd1);
    check("rst_press_num", NumIn, 8'h55);

    // Reset while in HELD, button kept down.
    Reset = 1'b1;
    #1;
    check_reset_outputs("rst_held");
    step(2);
    Reset = 1'b0;
    measure_start();
    step(12);
    check("rst_held_offset", 8'(first_pulse - t0), 8'd7);
    check("rst_held_pulses", 8'(pulse_cnt), 8'd1);
    BtnRaw = 1'b0;
    step(10);

    // Randomized segments: button levels, switches, occasional long holds.
    for (int i = 0; i < 60; i++) begin
      BtnRaw = 1'($urandom_range(0, 1));
      SwNum  = 8'($urandom);
      SwOp   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) step($urandom_range(10, 30));
      else                           step($urandom_range(1, 6));
    end
    BtnRaw = 1'b0;
    step(12);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the run is bounded even if something stalls.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
